// File: rtl/grid_pkg.sv
// Shared definitions for the row-collapsing grid memory: clear-engine state
// encoding, the empty-cell value and the default grid geometry.
package grid_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_TOP   = 2'd3
    } clr_state_e;

    localparam int EMPTY_CELL = 0;

    localparam int CELL_W_DEF = 3;
    localparam int COLS_DEF   = 10;
    localparam int ROWS_DEF   = 20;

endpackage

// File: rtl/grid_clr_ctrl.sv
// Clear engine for grid_row_mem: power-up zeroing sweep and row-collapse
// sequencing. The pointer doubles as the INIT row counter and the SHIFT
// destination row.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_INIT  | zero row ptr, one row per cycle, 0 .. ROWS-1
//   ST_IDLE  | port A writes allowed, clr_req accepted
//   ST_SHIFT | row[ptr] <= row[ptr-1], ptr counts down to 1
//   ST_TOP   | row 0 <= all-empty, then back to idle with clr_done
module grid_clr_ctrl
    import grid_pkg::*;
#(
    parameter int ROWS   = ROWS_DEF,
    parameter int ROW_AW = $clog2(ROWS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    input  logic [ROW_AW-1:0] clr_row,
    output logic              busy,
    output logic              init_we,
    output logic              shift_we,
    output logic              top_we,
    output logic [ROW_AW-1:0] ptr,
    output logic              clr_done,
    output logic              clr_err
);

    clr_state_e        state_q, state_d;
    logic [ROW_AW-1:0] p_q, p_d;
    logic              clr_done_q, clr_done_d;
    logic              clr_err_q, clr_err_d;

    // Next-state, pointer and completion/rejection pulse decode
    always_comb begin
        state_d    = state_q;
        p_d        = p_q;
        clr_done_d = 1'b0;
        clr_err_d  = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (p_q == ROW_AW'(ROWS - 1)) begin
                    state_d = ST_IDLE;
                    p_d     = '0;
                end else begin
                    p_d = p_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (clr_req) begin
                    if (int'(clr_row) >= ROWS) begin
                        clr_err_d = 1'b1;
                    end else begin
                        p_d     = clr_row;
                        state_d = (clr_row == '0) ? ST_TOP : ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                p_d = p_q - 1'b1;
                if (p_q == ROW_AW'(1)) begin
                    state_d = ST_TOP;
                end
            end
            ST_TOP: begin
                state_d    = ST_IDLE;
                clr_done_d = 1'b1;
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Engine registers; reset restarts the zeroing sweep and drops any collapse in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            p_q        <= '0;
            clr_done_q <= 1'b0;
            clr_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            p_q        <= p_d;
            clr_done_q <= clr_done_d;
            clr_err_q  <= clr_err_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign init_we  = (state_q == ST_INIT);
    assign shift_we = (state_q == ST_SHIFT);
    assign top_we   = (state_q == ST_TOP);
    assign ptr      = p_q;
    assign clr_done = clr_done_q;
    assign clr_err  = clr_err_q;

endmodule

// File: rtl/grid_row_mem.sv
// Row-organised grid store with a masked write-first port A, a forwarding
// read port B with row-full flag, and a clear engine that removes one row and
// collapses everything above it down by one.
module grid_row_mem
    import grid_pkg::*;
#(
    parameter int CELL_W = CELL_W_DEF,
    parameter int COLS   = COLS_DEF,
    parameter int ROWS   = ROWS_DEF,
    localparam int ROW_AW = $clog2(ROWS),
    localparam int ROW_W  = COLS * CELL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ROW_AW-1:0] addr_a,
    input  logic [ROW_W-1:0]  data_a,
    input  logic [COLS-1:0]   mask_a,
    input  logic              we_a,
    input  logic [ROW_AW-1:0] addr_b,
    output logic [ROW_W-1:0]  q_a,
    output logic [ROW_W-1:0]  q_b,
    output logic              full_b,
    input  logic              clr_req,
    input  logic [ROW_AW-1:0] clr_row,
    output logic              busy,
    output logic              clr_done,
    output logic              clr_err
);

    logic [ROW_W-1:0]  mem_q [ROWS];
    logic [ROW_W-1:0]  mem_d [ROWS];
    logic [ROW_W-1:0]  q_a_q, q_a_d;
    logic [ROW_W-1:0]  q_b_q, q_b_d;
    logic              full_b_q, full_b_d;

    logic              init_we, shift_we, top_we;
    logic [ROW_AW-1:0] ptr;
    logic              addr_a_ok, addr_b_ok, wr_ok;
    logic [ROW_W-1:0]  cur_a, cur_b, merged_a;

    grid_clr_ctrl #(
        .ROWS   (ROWS),
        .ROW_AW (ROW_AW)
    ) u_clr_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .clr_row  (clr_row),
        .busy     (busy),
        .init_we  (init_we),
        .shift_we (shift_we),
        .top_we   (top_we),
        .ptr      (ptr),
        .clr_done (clr_done),
        .clr_err  (clr_err)
    );

    // Row lookup and masked merge; out-of-range rows read as empty and are never written
    always_comb begin
        addr_a_ok = (int'(addr_a) < ROWS);
        addr_b_ok = (int'(addr_b) < ROWS);
        cur_a     = addr_a_ok ? mem_q[addr_a] : '0;
        cur_b     = addr_b_ok ? mem_q[addr_b] : '0;
        wr_ok     = we_a && !busy && addr_a_ok;
        merged_a  = cur_a;
        for (int c = 0; c < COLS; c++) begin
            if (mask_a[c]) begin
                merged_a[c*CELL_W +: CELL_W] = data_a[c*CELL_W +: CELL_W];
            end
        end
    end

    // Array update: port A writes only in idle, engine ops only while busy, so they never collide
    always_comb begin
        mem_d = mem_q;
        if (wr_ok) begin
            mem_d[addr_a] = merged_a;
        end
        if (init_we) begin
            mem_d[ptr] = '0;
        end
        if (shift_we) begin
            mem_d[ptr] = mem_q[ptr - 1'b1];
        end
        if (top_we) begin
            mem_d[0] = '0;
        end
    end

    // Read data: write-first on A, write-to-read forwarding on B, full flag from the forwarded row
    always_comb begin
        q_a_d    = wr_ok ? merged_a : cur_a;
        q_b_d    = (wr_ok && (addr_b == addr_a)) ? merged_a : cur_b;
        full_b_d = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (q_b_d[c*CELL_W +: CELL_W] == CELL_W'(EMPTY_CELL)) begin
                full_b_d = 1'b0;
            end
        end
    end

    // Storage and read registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) begin
                mem_q[r] <= '0;
            end
            q_a_q    <= '0;
            q_b_q    <= '0;
            full_b_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            q_a_q    <= q_a_d;
            q_b_q    <= q_b_d;
            full_b_q <= full_b_d;
        end
    end

    assign q_a    = q_a_q;
    assign q_b    = q_b_q;
    assign full_b = full_b_q;

endmodule
